isa_reg_arbiter: RTL and testbench

- Shares the single register-file port (reg_id / reg_re / reg_we / reg_wd / reg_out) between N ISA execution units, e.g. the set/move/alu instruction units.
- Round-robin arbitration with ownership lock: a granted unit keeps the port until it drops its request, so its read-modify-write sequence cannot be interleaved with another unit's.
- Sits between the ISA units and the register file; the instruction decoder is unaware of it.

---
 rtl/isa_reg_arbiter.sv | 171 +++++++++++++++++
 tb/tb_isa_reg_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/isa_reg_arbiter.sv
// Round-robin arbiter that locks the single register-file port to one ISA unit per sequence.
// Define ISA_ARB_TIMEOUT_EN to bound ownership to TIMEOUT cycles with a forced release.
module isa_reg_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*ID_W-1:0]   u_id,
  input  logic [N-1:0]        u_re,
  input  logic [N-1:0]        u_we,
  input  logic [N*DATA_W-1:0] u_wd,
  output logic [N-1:0]        grant,
  output logic [DATA_W-1:0]   u_rdata,
  output logic                busy,
  output logic                timeout_err,
  output logic [ID_W-1:0]     reg_id,
  output logic                reg_re,
  output logic                reg_we,
  output logic [DATA_W-1:0]   reg_wd,
  input  logic [DATA_W-1:0]   reg_out
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [PTR_W-1:0]  owner, owner_next;
  logic [PTR_W-1:0]  pick;
  logic              found;
  int unsigned       idx;
  logic [N-1:0]      grant_next;
  logic [ID_W-1:0]   reg_id_next;
  logic              reg_re_next, reg_we_next, busy_next;
  logic [DATA_W-1:0] reg_wd_next;
  logic              timeout_hit;

  logic [ID_W-1:0]   id_a [N];
  logic [DATA_W-1:0] wd_a [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign id_a[k] = u_id[k*ID_W +: ID_W];
    assign wd_a[k] = u_wd[k*DATA_W +: DATA_W];
  end

  assign u_rdata = reg_out;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // Next-state and registered port values.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    owner_next  = owner;
    grant_next  = grant;
    reg_id_next = reg_id;
    reg_wd_next = reg_wd;
    reg_re_next = 1'b0;
    reg_we_next = 1'b0;
    case (state)
      IDLE: begin
        grant_next = '0;
        if (found) begin
          owner_next        = pick;
          grant_next[pick]  = 1'b1;
          state_next        = OWN;
        end
      end
      OWN: begin
        if (!req[owner] || timeout_hit) begin
          grant_next = '0;
          ptr_next   = (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);
          state_next = RELEASE;
        end else begin
          reg_id_next = id_a[owner];
          reg_re_next = u_re[owner];
          reg_we_next = u_we[owner];
          reg_wd_next = wd_a[owner];
        end
      end
      RELEASE: begin
        grant_next = '0;
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      reg_id <= '0;
      reg_re <= 1'b0;
      reg_we <= 1'b0;
      reg_wd <= '0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      owner  <= owner_next;
      grant  <= grant_next;
      busy   <= busy_next;
      reg_id <= reg_id_next;
      reg_re <= reg_re_next;
      reg_we <= reg_we_next;
      reg_wd <= reg_wd_next;
    end
  end

`ifdef ISA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout_err_next;

  assign timeout_hit = (state == OWN) && (cnt == CNT_W'(TIMEOUT));

  // Ownership age: zeroed on grant, counts every OWN cycle that keeps the port.
  always_comb begin
    cnt_next         = cnt;
    timeout_err_next = 1'b0;
    if (state == IDLE && found) begin
      cnt_next = '0;
    end else if (state == OWN) begin
      if (timeout_hit && req[owner]) begin
        timeout_err_next = 1'b1;
      end else if (req[owner]) begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      timeout_err <= timeout_err_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_isa_reg_arbiter.sv
// Directed bench for isa_reg_arbiter: reset, ownership, round-robin order, isolation, timeout.
module tb_isa_reg_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 4;
  localparam int unsigned DW   = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*ID_W-1:0] u_id;
  logic [N-1:0]    u_re, u_we;
  logic [N*DW-1:0] u_wd;
  logic [N-1:0]    grant;
  logic [DW-1:0]   u_rdata;
  logic            busy, timeout_err;
  logic [ID_W-1:0] reg_id;
  logic            reg_re, reg_we;
  logic [DW-1:0]   reg_wd;
  logic [DW-1:0]   reg_out;

  int checks   = 0;
  int failures = 0;

  isa_reg_arbiter #(.N(N), .ID_W(ID_W), .DATA_W(DW), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .req(req), .u_id(u_id), .u_re(u_re), .u_we(u_we),
    .u_wd(u_wd), .grant(grant), .u_rdata(u_rdata), .busy(busy),
    .timeout_err(timeout_err), .reg_id(reg_id), .reg_re(reg_re),
    .reg_we(reg_we), .reg_wd(reg_wd), .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [ID_W-1:0] id, input logic re,
                          input logic we, input logic [DW-1:0] wd);
    u_id[k*ID_W +: ID_W] = id;
    u_re[k] = re;
    u_we[k] = we;
    u_wd[k*DW +: DW] = wd;
  endtask

  logic [N-1:0] order [4];

  initial begin
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; u_id = '0; u_re = '0; u_we = '0; u_wd = '0; reg_out = '0;

    // Reset state and quiet idle.
    tick(); tick();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_re", 64'(reg_re), 64'h0);
    check("rst_we", 64'(reg_we), 64'h0);
    check("rst_id", 64'(reg_id), 64'h0);
    check("rst_wd", reg_wd, 64'h0);
    check("rst_terr", 64'(timeout_err), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 64'(grant), 64'h0);
      check("idle_busy", 64'(busy), 64'h0);
      check("idle_en", 64'({reg_re, reg_we}), 64'h0);
    end

    // Single owner: read then write, one-cycle latency.
    req = 4'b0100;
    tick();
    check("u2_grant", 64'(grant), 64'h4);
    check("u2_busy", 64'(busy), 64'h1);
    check("u2_re0", 64'(reg_re), 64'h0);
    set_unit(2, 4'd3, 1'b1, 1'b0, 64'h0);
    tick();
    check("u2_id", 64'(reg_id), 64'h3);
    check("u2_re", 64'(reg_re), 64'h1);
    check("u2_we0", 64'(reg_we), 64'h0);
    set_unit(2, 4'd3, 1'b0, 1'b1, 64'h1234);
    reg_out = 64'hCAFE;
    #1;
    check("rdata", u_rdata, 64'hCAFE);
    tick();
    check("u2_we", 64'(reg_we), 64'h1);
    check("u2_wd", reg_wd, 64'h1234);
    check("u2_re_off", 64'(reg_re), 64'h0);
    req = 4'b0000;
    set_unit(2, 4'd0, 1'b0, 1'b0, 64'h0);
    tick();
    check("rel_grant", 64'(grant), 64'h0);
    check("rel_busy", 64'(busy), 64'h1);
    check("rel_we", 64'(reg_we), 64'h0);
    check("rel_wd_hold", reg_wd, 64'h1234);
    check("rel_id_hold", 64'(reg_id), 64'h3);
    tick();
    check("post_rel_busy", 64'(busy), 64'h0);

    // Round-robin order with re-raised requests.
    rst = 1'b1; req = 4'b1011;
    tick();
    rst = 1'b0;
    check("rr_start", 64'(grant), 64'h0);
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check("rr_grant", 64'(grant), 64'(order[j]));
      end
      req = req & ~order[j];
      tick();
      check("rr_rel_grant", 64'(grant), 64'h0);
      check("rr_rel_busy", 64'(busy), 64'h1);
      req = req | order[j];
      tick();
      check("rr_idle_grant", 64'(grant), 64'h0);
      check("rr_idle_busy", 64'(busy), 64'h0);
    end

    // Non-owner signals must not leak onto the port.
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    set_unit(1, 4'd2, 1'b0, 1'b0, 64'h0);
    set_unit(3, 4'd7, 1'b0, 1'b1, 64'hBEEF);
    req = 4'b1010;
    tick();
    check("iso_grant", 64'(grant), 64'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("iso_we", 64'(reg_we), 64'h0);
      check("iso_id", 64'(reg_id), 64'h2);
      check("iso_grant_hold", 64'(grant), 64'h2);
    end
    req = 4'b1000;
    tick();
    check("iso_rel", 64'(grant), 64'h0);
    tick();
    tick();
    check("u3_grant", 64'(grant), 64'h8);
    check("u3_we0", 64'(reg_we), 64'h0);
    tick();
    check("u3_we", 64'(reg_we), 64'h1);
    check("u3_id", 64'(reg_id), 64'h7);
    check("u3_wd", reg_wd, 64'hBEEF);

    // Reset mid-ownership while writing.
    req = 4'b1001; rst = 1'b1;
    tick();
    check("mrst_grant", 64'(grant), 64'h0);
    check("mrst_id", 64'(reg_id), 64'h0);
    check("mrst_re", 64'(reg_re), 64'h0);
    check("mrst_we", 64'(reg_we), 64'h0);
    check("mrst_wd", reg_wd, 64'h0);
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_terr", 64'(timeout_err), 64'h0);
    rst = 1'b0;
    set_unit(3, 4'd0, 1'b0, 1'b0, 64'h0);
    tick();
    check("mrst_first", 64'(grant), 64'h1);

    // Unit 0 never drops its request while unit 1 waits.
    req = 4'b0011;
`ifdef ISA_ARB_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      check("to_hold", 64'(grant), 64'h1);
      check("to_terr0", 64'(timeout_err), 64'h0);
    end
    tick();
    check("to_rel_grant", 64'(grant), 64'h0);
    check("to_terr", 64'(timeout_err), 64'h1);
    check("to_busy", 64'(busy), 64'h1);
    tick();
    check("to_terr_pulse", 64'(timeout_err), 64'h0);
    check("to_idle", 64'(busy), 64'h0);
    tick();
    check("to_next", 64'(grant), 64'h2);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nto_hold", 64'(grant), 64'h1);
      check("nto_terr", 64'(timeout_err), 64'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
